// File: rtl/cpu_mem_responder.sv
// 256x16 single-port RAM for CPU_top with a byte-stream boot loader that holds the CPU in reset.
// Optional CPU write protection below PROT_TOP is compiled in with `define MEM_WR_PROTECT_EN.
module cpu_mem_responder #(
    parameter int LOAD_WORDS = 256,
    parameter int PROT_TOP   = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cpu_address,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_we,
    output logic [15:0] cpu_rdata,
    output logic        cpu_rst_n,
    input  logic [7:0]  load_data,
    input  logic        load_valid,
    output logic        load_ready,
    output logic        load_done,
    output logic        wr_fault
);

    typedef enum logic [1:0] {LOAD_HI, LOAD_LO, RUN} state_t;

    localparam logic [8:0] LOAD_LAST = 9'(LOAD_WORDS);
    localparam logic [8:0] PROT_LIM  = 9'(PROT_TOP);

    state_t      state_q, state_d;
    logic [8:0]  load_ptr_q, load_ptr_d;
    logic [7:0]  hi_byte_q, hi_byte_d;
    logic [15:0] rdata_q;
    logic [15:0] mem_q [256];

    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [15:0] mem_wdata;
    logic [8:0]  ptr_inc;

`ifdef MEM_WR_PROTECT_EN
    logic fault_q, fault_d;
    logic prot_hit;
    assign prot_hit = ({1'b0, cpu_address} < PROT_LIM);
`else
    logic prot_unused;
    assign prot_unused = ^PROT_LIM;
`endif

    assign ptr_inc = load_ptr_q + 9'd1;

    always_comb begin
        state_d    = state_q;
        load_ptr_d = load_ptr_q;
        hi_byte_d  = hi_byte_q;
        mem_we     = 1'b0;
        mem_waddr  = cpu_address;
        mem_wdata  = cpu_wdata;
`ifdef MEM_WR_PROTECT_EN
        fault_d    = 1'b0;
`endif
        case (state_q)
            LOAD_HI: begin
                if (load_valid) begin
                    hi_byte_d = load_data;
                    state_d   = LOAD_LO;
                end
            end
            LOAD_LO: begin
                if (load_valid) begin
                    mem_we     = 1'b1;
                    mem_waddr  = load_ptr_q[7:0];
                    mem_wdata  = {hi_byte_q, load_data};
                    load_ptr_d = ptr_inc;
                    state_d    = (ptr_inc == LOAD_LAST) ? RUN : LOAD_HI;
                end
            end
            RUN: begin
                if (cpu_we) begin
`ifdef MEM_WR_PROTECT_EN
                    if (prot_hit) begin
                        fault_d = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                    end
`else
                    mem_we = 1'b1;
`endif
                end
            end
            default: state_d = LOAD_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD_HI;
            load_ptr_q <= 9'd0;
            hi_byte_q  <= 8'h00;
            rdata_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            load_ptr_q <= load_ptr_d;
            hi_byte_q  <= hi_byte_d;
            rdata_q    <= (state_q == RUN) ? mem_q[cpu_address] : 16'h0000;
        end
    end

    // RAM is never cleared; reset only suppresses a write landing on the same edge.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

`ifdef MEM_WR_PROTECT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
    assign wr_fault = fault_q;
`else
    assign wr_fault = 1'b0;
`endif

    assign cpu_rdata  = rdata_q;
    assign load_ready = (state_q != RUN);
    assign cpu_rst_n  = (state_q == RUN);
    assign load_done  = (state_q == RUN);

endmodule
